multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/ctrl_pkg.sv | 74 +++++++
 rtl/opcode_decoder.sv | 50 +++++
 rtl/multicycle_control.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcode patterns, state/class enums and ALU/sign-extend codes for the
// LEGv8 multicycle control unit.
package ctrl_pkg;

    // Opcode prefixes, MSB-aligned; the unmatched low bits belong to immediates.
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [8:0]  OP_MOVZ = 9'b110100101;
    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;
    localparam logic [3:0] ALU_MOVZ  = 4'b1000;

    localparam logic [1:0] SIGN_NONE  = 2'b00;
    localparam logic [1:0] SIGN_DADDR = 2'b01;
    localparam logic [1:0] SIGN_BR    = 2'b10;
    localparam logic [1:0] SIGN_CBR   = 2'b11;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StTrap
    } state_e;

    typedef enum logic [3:0] {
        ClsIllegal,
        ClsAnd,
        ClsOrr,
        ClsAdd,
        ClsSub,
        ClsAddi,
        ClsSubi,
        ClsMovz,
        ClsB,
        ClsCbz,
        ClsLdur,
        ClsStur
    } instr_class_e;

    function automatic logic [3:0] class_aluop(instr_class_e cls);
        case (cls)
            ClsOrr:                             return ALU_ORR;
            ClsAdd, ClsAddi, ClsLdur, ClsStur:  return ALU_ADD;
            ClsSub, ClsSubi:                    return ALU_SUB;
            ClsCbz:                             return ALU_PASSB;
            ClsMovz:                            return ALU_MOVZ;
            default:                            return ALU_AND;
        endcase
    endfunction

    function automatic logic [1:0] class_signop(instr_class_e cls);
        case (cls)
            ClsLdur, ClsStur: return SIGN_DADDR;
            ClsB:             return SIGN_BR;
            ClsCbz:           return SIGN_CBR;
            default:          return SIGN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Combinational LEGv8 opcode classifier with the matching ALU and sign-extend codes.
module opcode_decoder
    import ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W = 11
) (
    input  logic [OPCODE_W-1:0] opcode,
    output instr_class_e        cls,
    output logic [3:0]          aluop,
    output logic [1:0]          signop
);

    logic [10:0]  op;
    instr_class_e cls_int;

    // The LEGv8 opcode occupies the top 11 bits of the field.
    assign op = opcode[OPCODE_W-1 -: 11];

    always_comb begin
        cls_int = ClsIllegal;
        if (op == OP_AND) begin
            cls_int = ClsAnd;
        end else if (op == OP_ORR) begin
            cls_int = ClsOrr;
        end else if (op == OP_ADD) begin
            cls_int = ClsAdd;
        end else if (op == OP_SUB) begin
            cls_int = ClsSub;
        end else if (op[10:1] == OP_ADDI) begin
            cls_int = ClsAddi;
        end else if (op[10:1] == OP_SUBI) begin
            cls_int = ClsSubi;
        end else if (op[10:2] == OP_MOVZ) begin
            cls_int = ClsMovz;
        end else if (op[10:5] == OP_B) begin
            cls_int = ClsB;
        end else if (op[10:3] == OP_CBZ) begin
            cls_int = ClsCbz;
        end else if (op == OP_LDUR) begin
            cls_int = ClsLdur;
        end else if (op == OP_STUR) begin
            cls_int = ClsStur;
        end
    end

    assign cls    = cls_int;
    assign aluop  = class_aluop(cls_int);
    assign signop = class_signop(cls_int);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle LEGv8 control FSM: fetch/decode/exec/mem/writeback with handshake
// timeouts, a sticky trap state and a retired-instruction counter.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W    = 11,
    parameter int unsigned ALUOP_W     = 4,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                imem_req,
    input  logic                imem_ready,
    output logic                dmem_req,
    input  logic                dmem_ready,
    output logic                ir_write,
    output logic                pc_write,
    output logic                reg2loc,
    output logic                alusrc,
    output logic                mem2reg,
    output logic                regwrite,
    output logic                memread,
    output logic                memwrite,
    output logic                branch,
    output logic                uncond_branch,
    output logic [ALUOP_W-1:0]  aluop,
    output logic [1:0]          signop,
    output logic                error,
    output logic [CNT_W-1:0]    retired
);

    localparam int unsigned       WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_e              state_q, state_d;
    instr_class_e        cls_q, cls_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    retired_q, retired_d;

    logic [OPCODE_W-1:0] dec_opcode;
    instr_class_e        dec_cls;
    logic [3:0]          dec_aluop;
    logic [1:0]          dec_signop;
    logic                timeout;

    // Live opcode is classified in DECODE; afterwards the latched copy drives the decoder.
    assign dec_opcode = (state_q == StDecode) ? opcode : opcode_q;

    opcode_decoder #(
        .OPCODE_W(OPCODE_W)
    ) u_decoder (
        .opcode(dec_opcode),
        .cls   (dec_cls),
        .aluop (dec_aluop),
        .signop(dec_signop)
    );

    // wait_q holds the number of ready-less cycles already spent in this handshake.
    assign timeout = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LAST);

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        opcode_d  = opcode_q;
        wait_d    = '0;
        retired_d = retired_q;
        unique case (state_q)
            StFetch: begin
                if (imem_ready) begin
                    state_d = StDecode;
                end else if (timeout) begin
                    state_d = StTrap;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StDecode: begin
                opcode_d = opcode;
                cls_d    = dec_cls;
                state_d  = (dec_cls == ClsIllegal) ? StTrap : StExec;
            end
            StExec: begin
                if (cls_q == ClsB || cls_q == ClsCbz) begin
                    state_d   = StFetch;
                    retired_d = retired_q + 1'b1;
                end else if (cls_q == ClsLdur || cls_q == ClsStur) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (dmem_ready) begin
                    if (cls_q == ClsLdur) begin
                        state_d = StWb;
                    end else begin
                        state_d   = StFetch;
                        retired_d = retired_q + 1'b1;
                    end
                end else if (timeout) begin
                    state_d = StTrap;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StWb: begin
                state_d   = StFetch;
                retired_d = retired_q + 1'b1;
            end
            StTrap: state_d = StTrap;
            default: state_d = StTrap;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= StFetch;
            cls_q     <= ClsIllegal;
            opcode_q  <= '0;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            opcode_q  <= opcode_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg2loc       = 1'b0;
        alusrc        = 1'b0;
        mem2reg       = 1'b0;
        regwrite      = 1'b0;
        memread       = 1'b0;
        memwrite      = 1'b0;
        branch        = 1'b0;
        uncond_branch = 1'b0;
        aluop         = '0;
        signop        = '0;
        error         = 1'b0;
        retired       = '0;
        if (!Reset) begin
            retired = retired_q;
            unique case (state_q)
                StFetch: begin
                    imem_req = 1'b1;
                    ir_write = imem_ready;
                end
                StExec: begin
                    aluop         = ALUOP_W'(dec_aluop);
                    signop        = dec_signop;
                    alusrc        = (cls_q == ClsAddi) || (cls_q == ClsSubi) ||
                                    (cls_q == ClsMovz) || (cls_q == ClsLdur) ||
                                    (cls_q == ClsStur);
                    reg2loc       = (cls_q == ClsCbz) || (cls_q == ClsStur);
                    branch        = (cls_q == ClsCbz);
                    uncond_branch = (cls_q == ClsB);
                    pc_write      = (cls_q == ClsCbz) || (cls_q == ClsB);
                end
                StMem: begin
                    dmem_req = 1'b1;
                    memread  = (cls_q == ClsLdur);
                    memwrite = (cls_q == ClsStur);
                    pc_write = dmem_ready && (cls_q == ClsStur);
                end
                StWb: begin
                    regwrite = 1'b1;
                    mem2reg  = (cls_q == ClsLdur);
                    pc_write = 1'b1;
                end
                StTrap: error = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench: the stimulus pushes the expected per-cycle output
// vector for every instruction phase; a negedge monitor pops and compares.
module tb_multicycle_control;

    localparam int unsigned CNT_W = 4;
    localparam int          TMO   = 16;

    typedef enum int {CAnd, COrr, CAdd, CSub, CAddi, CSubi, CMovz, CB, CCbz, CLdur, CStur, CIll}
        cls_t;

    typedef struct packed {
        logic             imem_req;
        logic             dmem_req;
        logic             ir_write;
        logic             pc_write;
        logic             reg2loc;
        logic             alusrc;
        logic             mem2reg;
        logic             regwrite;
        logic             memread;
        logic             memwrite;
        logic             branch;
        logic             uncond_branch;
        logic [3:0]       aluop;
        logic [1:0]       signop;
        logic             error;
        logic [CNT_W-1:0] retired;
    } obs_t;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic [10:0]      opcode = '0;
    logic             imem_ready = 1'b0;
    logic             dmem_ready = 1'b0;
    logic             imem_req, dmem_req, ir_write, pc_write, reg2loc, alusrc, mem2reg;
    logic             regwrite, memread, memwrite, branch, uncond_branch, error;
    logic [3:0]       aluop;
    logic [1:0]       signop;
    logic [CNT_W-1:0] retired;

    obs_t        exp_q[$];
    obs_t        got;
    int          checks = 0;
    int          errors = 0;
    bit          stim_done = 1'b0;
    int unsigned n_ret = 0;

    multicycle_control #(
        .OPCODE_W   (11),
        .ALUOP_W    (4),
        .MEM_TIMEOUT(TMO),
        .CNT_W      (CNT_W)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .opcode       (opcode),
        .imem_req     (imem_req),
        .imem_ready   (imem_ready),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .reg2loc      (reg2loc),
        .alusrc       (alusrc),
        .mem2reg      (mem2reg),
        .regwrite     (regwrite),
        .memread      (memread),
        .memwrite     (memwrite),
        .branch       (branch),
        .uncond_branch(uncond_branch),
        .aluop        (aluop),
        .signop       (signop),
        .error        (error),
        .retired      (retired)
    );

    always #5 Clk = ~Clk;

    assign got = {imem_req, dmem_req, ir_write, pc_write, reg2loc, alusrc, mem2reg, regwrite,
                  memread, memwrite, branch, uncond_branch, aluop, signop, error, retired};

    function automatic logic [10:0] make_op(cls_t c);
        logic [10:0] r = 11'($urandom);
        case (c)
            CAnd:    return 11'b10001010000;
            COrr:    return 11'b10101010000;
            CAdd:    return 11'b10001011000;
            CSub:    return 11'b11001011000;
            CAddi:   return {10'b1001000100, r[0]};
            CSubi:   return {10'b1101000100, r[0]};
            CMovz:   return {9'b110100101, r[1:0]};
            CB:      return {6'b000101, r[4:0]};
            CCbz:    return {8'b10110100, r[2:0]};
            CLdur:   return 11'b11111000010;
            CStur:   return 11'b11111000000;
            default: begin
                case (r[1:0])
                    2'd0:    return 11'b00000000000;
                    2'd1:    return 11'b11111111111;
                    2'd2:    return 11'b10001011001;
                    default: return 11'b11111000011;
                endcase
            end
        endcase
    endfunction

    function automatic obs_t base();
        obs_t e = '0;
        e.retired = CNT_W'(n_ret);
        return e;
    endfunction

    function automatic obs_t exec_obs(cls_t c);
        obs_t e = base();
        case (c)
            COrr:                      e.aluop = 4'b0001;
            CAdd, CAddi, CLdur, CStur: e.aluop = 4'b0010;
            CSub, CSubi:               e.aluop = 4'b0110;
            CCbz:                      e.aluop = 4'b0111;
            CMovz:                     e.aluop = 4'b1000;
            default:                   e.aluop = 4'b0000;
        endcase
        e.alusrc  = (c == CAddi || c == CSubi || c == CMovz || c == CLdur || c == CStur);
        e.reg2loc = (c == CCbz || c == CStur);
        e.signop  = (c == CLdur || c == CStur) ? 2'b01 : (c == CB) ? 2'b10 :
                    (c == CCbz) ? 2'b11 : 2'b00;
        e.branch        = (c == CCbz);
        e.uncond_branch = (c == CB);
        e.pc_write      = (c == CCbz || c == CB);
        return e;
    endfunction

    task automatic noise();
        opcode     = 11'($urandom);
        imem_ready = 1'($urandom);
        dmem_ready = 1'($urandom);
    endtask

    task automatic tick(input obs_t e);
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        Reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            noise();
            tick('0);
        end
        Reset = 1'b0;
        n_ret = 0;
    endtask

    task automatic trap_hold();
        obs_t e;
        for (int i = 0; i < 3; i++) begin
            noise();
            e = base();
            e.error = 1'b1;
            tick(e);
        end
        do_reset(1);
    endtask

    // Drives one instruction from FETCH; abort_mem >= 0 resets during that MEM wait cycle.
    task automatic run_instr(input cls_t c, input logic [10:0] op, input int imem_dly,
                             input int dmem_dly, input int abort_mem);
        obs_t e;
        for (int k = 0; k < imem_dly && k < TMO; k++) begin
            noise();
            imem_ready = 1'b0;
            e = base();
            e.imem_req = 1'b1;
            tick(e);
        end
        if (imem_dly >= TMO) begin
            trap_hold();
            return;
        end
        noise();
        imem_ready = 1'b1;
        e = base();
        e.imem_req = 1'b1;
        e.ir_write = 1'b1;
        tick(e);
        noise();
        opcode = op;
        tick(base());
        if (c == CIll) begin
            trap_hold();
            return;
        end
        noise();
        tick(exec_obs(c));
        if (c == CB || c == CCbz) begin
            n_ret++;
            return;
        end
        if (c == CLdur || c == CStur) begin
            for (int k = 0; k < dmem_dly && k < TMO; k++) begin
                if (k == abort_mem) begin
                    do_reset(1);
                    return;
                end
                noise();
                dmem_ready = 1'b0;
                e = base();
                e.dmem_req = 1'b1;
                e.memread  = (c == CLdur);
                e.memwrite = (c == CStur);
                tick(e);
            end
            if (dmem_dly >= TMO) begin
                trap_hold();
                return;
            end
            noise();
            dmem_ready = 1'b1;
            e = base();
            e.dmem_req = 1'b1;
            e.memread  = (c == CLdur);
            e.memwrite = (c == CStur);
            e.pc_write = (c == CStur);
            tick(e);
            if (c == CStur) begin
                n_ret++;
                return;
            end
        end
        noise();
        e = base();
        e.regwrite = 1'b1;
        e.mem2reg  = (c == CLdur);
        e.pc_write = 1'b1;
        tick(e);
        n_ret++;
    endtask

    initial begin
        cls_t c;
        int   idly, ddly, abort;
        @(posedge Clk);
        #1;
        do_reset(2);
        run_instr(CAdd, 11'b10001011000, 0, 0, -1);
        run_instr(CLdur, 11'b11111000010, 0, 3, -1);
        run_instr(CCbz, 11'b10110100101, 0, 0, -1);
        run_instr(CIll, 11'b00000000000, 0, 0, -1);
        run_instr(CAdd, make_op(CAdd), TMO, 0, -1);
        run_instr(CAdd, make_op(CAdd), TMO - 1, 0, -1);
        run_instr(CStur, make_op(CStur), 0, 10, 2);
        run_instr(CSubi, make_op(CSubi), 0, 0, -1);
        run_instr(CStur, make_op(CStur), 0, TMO, -1);
        run_instr(CLdur, make_op(CLdur), 1, TMO - 1, -1);
        for (int i = 0; i < 18; i++) run_instr(CB, make_op(CB), 0, 0, -1);
        for (int i = 0; i < 80; i++) begin
            c    = cls_t'($urandom_range(0, 11));
            idly = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TMO - 2, TMO))
                                               : int'($urandom_range(0, 3));
            ddly = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TMO - 2, TMO))
                                               : int'($urandom_range(0, 4));
            abort = (ddly > 0 && $urandom_range(0, 7) == 0) ? int'($urandom_range(0, ddly - 1))
                                                            : -1;
            run_instr(c, make_op(c), idly, ddly, abort);
        end
        stim_done = 1'b1;
    end

    initial begin
        obs_t e;
        int   cyc = 0;
        forever begin
            @(negedge Clk);
            if (stim_done) break;
            cyc++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL cycle %0d scoreboard empty: got %h want <queued vector>", cyc, got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL cycle %0d ctrl vector: got %h want %h", cyc, got, e);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover expectations: got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
